// File: rtl/reg_bank_pkg.sv
// Shared defaults and helpers for the reg_bank_multi register file.
package reg_bank_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REG    = 32;
    localparam int DEFAULT_NUM_READ   = 2;

    // Template for users sizing their own index fields:
    //   typedef logic [$clog2(NUM_REG)-1:0] reg_idx_t;
    typedef logic [$clog2(DEFAULT_NUM_REG)-1:0] reg_idx_t;

    // The pending counter must hold every value from 0 to NUM_REG inclusive.
    function automatic int pending_count_width(input int num_reg);
        return $clog2(num_reg + 1);
    endfunction

endpackage

// File: rtl/reg_bank_multi_read_port.sv
// One combinational read port: range check, zero-register masking and,
// with REG_BANK_BYPASS_EN defined, same-cycle forwarding of the writeback value.
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int NUM_REG      = DEFAULT_NUM_REG,
    parameter int ZERO_REG     = 1,
    parameter int SELECT_WIDTH = $clog2(DEFAULT_NUM_REG)
) (
    input  logic [NUM_REG-1:0][DATA_WIDTH-1:0] reg_data,
    input  logic [NUM_REG-1:0]                 reg_pending,
    input  logic [SELECT_WIDTH-1:0]            read_select,
    input  logic                               write_enable,
    input  logic [SELECT_WIDTH-1:0]            write_select,
    input  logic [DATA_WIDTH-1:0]              write_data,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_busy
);

    logic readable;

    // Invalid indices and the hardwired zero register read as 0 / not busy.
    assign readable = (int'(read_select) < NUM_REG) && !(ZERO_REG != 0 && read_select == '0);

    always_comb begin
        read_data = '0;
        read_busy = 1'b0;
        if (readable) begin
            read_data = reg_data[read_select];
            read_busy = reg_pending[read_select];
        end
`ifdef REG_BANK_BYPASS_EN
        if (readable && write_enable && write_select == read_select) begin
            read_data = write_data;
            read_busy = 1'b0;
        end
`endif
    end

`ifndef REG_BANK_BYPASS_EN
    logic unused_write;
    assign unused_write = ^{write_enable, write_select, write_data};
`endif

endmodule

// File: rtl/reg_bank_multi.sv
// Multi-read, single-write register file with per-register pending bits.
// Optional same-cycle write-to-read forwarding: define REG_BANK_BYPASS_EN.
module reg_bank_multi
    import reg_bank_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REG      = DEFAULT_NUM_REG,
    parameter  int NUM_READ     = DEFAULT_NUM_READ,
    parameter  int ZERO_REG     = 1,
    localparam int SELECT_WIDTH = $clog2(NUM_REG),
    localparam int COUNT_WIDTH  = pending_count_width(NUM_REG)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_write_enable,
    input  logic [SELECT_WIDTH-1:0]          i_write_select,
    input  logic [DATA_WIDTH-1:0]            i_write_data,
    input  logic                             i_reserve_enable,
    input  logic [SELECT_WIDTH-1:0]          i_reserve_select,
    input  logic [NUM_READ*SELECT_WIDTH-1:0] i_read_select,
    output logic [NUM_READ*DATA_WIDTH-1:0]   o_read_data,
    output logic [NUM_READ-1:0]              o_read_busy,
    output logic [COUNT_WIDTH-1:0]           o_pending_count
);

    logic [NUM_REG-1:0][DATA_WIDTH-1:0] reg_data;
    logic [NUM_REG-1:0]                 reg_pending;
    logic [COUNT_WIDTH-1:0]             pending_count;
    logic                               write_ok;
    logic                               reserve_ok;
    logic                               count_inc;
    logic                               count_dec;

    function automatic logic idx_ok(input logic [SELECT_WIDTH-1:0] sel);
        return (int'(sel) < NUM_REG) && !(ZERO_REG != 0 && sel == '0);
    endfunction

    assign write_ok   = i_write_enable && idx_ok(i_write_select);
    assign reserve_ok = i_reserve_enable && idx_ok(i_reserve_select);

    // A reserve on the register being written keeps it pending, so no decrement.
    assign count_inc = reserve_ok && !reg_pending[i_reserve_select];
    assign count_dec = write_ok && reg_pending[i_write_select] &&
                       !(reserve_ok && i_reserve_select == i_write_select);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_data      <= '0;
            reg_pending   <= '0;
            pending_count <= '0;
        end else begin
            if (write_ok) begin
                reg_data[i_write_select]    <= i_write_data;
                reg_pending[i_write_select] <= 1'b0;
            end
            if (reserve_ok) begin
                reg_pending[i_reserve_select] <= 1'b1;
            end
            case ({count_inc, count_dec})
                2'b10:   pending_count <= pending_count + COUNT_WIDTH'(1);
                2'b01:   pending_count <= pending_count - COUNT_WIDTH'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    assign o_pending_count = pending_count;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        reg_read_port #(
            .DATA_WIDTH  (DATA_WIDTH),
            .NUM_REG     (NUM_REG),
            .ZERO_REG    (ZERO_REG),
            .SELECT_WIDTH(SELECT_WIDTH)
        ) u_port (
            .reg_data    (reg_data),
            .reg_pending (reg_pending),
            .read_select (i_read_select[p*SELECT_WIDTH +: SELECT_WIDTH]),
            .write_enable(i_write_enable),
            .write_select(i_write_select),
            .write_data  (i_write_data),
            .read_data   (o_read_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .read_busy   (o_read_busy[p])
        );
    end

endmodule

// File: tb/tb_reg_bank_multi.sv
// Scoreboard bench for reg_bank_multi (NUM_REG=10, two read ports, zero register on).
module tb_reg_bank_multi;

    localparam int DW  = 32;
    localparam int NR  = 10;
    localparam int NRD = 2;
    localparam int SW  = 4;
    localparam int CW  = 4;
`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     we    = 1'b0;
    logic [SW-1:0]            wsel  = '0;
    logic [DW-1:0]            wdata = '0;
    logic                     re    = 1'b0;
    logic [SW-1:0]            rsv   = '0;
    logic [NRD-1:0][SW-1:0]   rsel  = '0;
    logic [NRD-1:0][DW-1:0]   rdata;
    logic [NRD-1:0]           busy;
    logic [CW-1:0]            cnt;

    typedef struct {
        string                  name;
        logic [NRD-1:0][DW-1:0] data;
        logic [NRD-1:0]         busy;
        logic [CW-1:0]          cnt;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    reg_bank_multi #(
        .DATA_WIDTH(DW),
        .NUM_REG   (NR),
        .NUM_READ  (NRD),
        .ZERO_REG  (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_write_enable  (we),
        .i_write_select  (wsel),
        .i_write_data    (wdata),
        .i_reserve_enable(re),
        .i_reserve_select(rsv),
        .i_read_select   (rsel),
        .o_read_data     (rdata),
        .o_read_busy     (busy),
        .o_pending_count (cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [SW-1:0] ws, input logic [DW-1:0] wd,
                         input logic r, input logic [SW-1:0] rs,
                         input logic [SW-1:0] r0, input logic [SW-1:0] r1);
        we = w; wsel = ws; wdata = wd; re = r; rsv = rs;
        rsel[0] = r0; rsel[1] = r1;
    endtask

    task automatic want(input string name, input logic [DW-1:0] d0, input logic b0,
                        input logic [DW-1:0] d1, input logic b1, input int c);
        snap_t s;
        s.name = name; s.data[0] = d0; s.data[1] = d1; s.busy = {b1, b0}; s.cnt = CW'(c);
        exp_q.push_back(s);
    endtask

    task automatic capture();
        snap_t s;
        #2;
        s.name = ""; s.data = rdata; s.busy = busy; s.cnt = cnt;
        obs_q.push_back(s);
    endtask

    task automatic test_reset();
        snap_t e, o;
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd5, 4'd0);
        want("reset_hold", '0, 1'b0, '0, 1'b0, 0); capture();
        tick(); rst_n = 1'b1;
        drive(1'b1, 4'd5, 32'hAA, 1'b1, 4'd2, 4'd5, 4'd2); tick();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd5, 4'd2);
        want("pre_reset", 32'hAA, 1'b0, '0, 1'b1, 1); capture();
        tick(); rst_n = 1'b0;
        want("async_reset", '0, 1'b0, '0, 1'b0, 0); capture();
        tick(); rst_n = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_write_read();
        snap_t e, o;
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 4'd3, 4'd3);
        want("wr_same_cycle", BYP ? 32'hDEADBEEF : 32'h0, 1'b0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0, 0);
        capture(); tick();
        drive(1'b1, 4'd0, 32'h1234, 1'b0, 4'd0, 4'd3, 4'd0);
        want("wr_visible", 32'hDEADBEEF, 1'b0, '0, 1'b0, 0); capture(); tick();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0, 4'd0);
        want("zero_reg", '0, 1'b0, '0, 1'b0, 0); capture(); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_scoreboard();
        snap_t e, o;
        drive(1'b0, 4'd0, '0, 1'b1, 4'd7, 4'd7, 4'd7); tick();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd7, 4'd7);
        want("reserve", '0, 1'b1, '0, 1'b1, 1); capture(); tick();
        drive(1'b1, 4'd7, 32'h55, 1'b0, 4'd0, 4'd7, 4'd7);
        want("wb_same_cycle", BYP ? 32'h55 : 32'h0, !BYP, BYP ? 32'h55 : 32'h0, !BYP, 1);
        capture(); tick();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd7, 4'd7);
        want("wb_release", 32'h55, 1'b0, 32'h55, 1'b0, 0); capture(); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_collision();
        snap_t e, o;
        drive(1'b0, 4'd0, '0, 1'b1, 4'd9, 4'd9, 4'd8); tick();
        drive(1'b1, 4'd9, 32'h77, 1'b1, 4'd9, 4'd9, 4'd8);
        want("coll_before", BYP ? 32'h77 : 32'h0, !BYP, '0, 1'b0, 1); capture(); tick();
        drive(1'b1, 4'd9, 32'h88, 1'b1, 4'd8, 4'd9, 4'd8);
        want("coll_same_reg", BYP ? 32'h88 : 32'h77, !BYP, '0, 1'b0, 1); capture(); tick();
        drive(1'b0, 4'd0, '0, 1'b1, 4'd8, 4'd9, 4'd8);
        want("diff_regs", 32'h88, 1'b0, '0, 1'b1, 1); capture(); tick();
        drive(1'b1, 4'd6, 32'h66, 1'b1, 4'd6, 4'd8, 4'd6);
        want("re_reserve", '0, 1'b1, BYP ? 32'h66 : 32'h0, 1'b0, 1); capture(); tick();
        drive(1'b1, 4'd8, 32'h80, 1'b0, 4'd0, 4'd6, 4'd8);
        want("coll_fresh", 32'h66, 1'b1, BYP ? 32'h80 : 32'h0, !BYP, 2); capture(); tick();
        drive(1'b1, 4'd6, 32'h60, 1'b0, 4'd0, 4'd6, 4'd8);
        want("release8", BYP ? 32'h60 : 32'h66, !BYP, 32'h80, 1'b0, 1); capture(); tick();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd6, 4'd8);
        want("release6", 32'h60, 1'b0, 32'h80, 1'b0, 0); capture(); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_out_of_range();
        snap_t e, o;
        drive(1'b1, 4'd12, 32'hCC, 1'b1, 4'd12, 4'd12, 4'd15);
        want("oor_same", '0, 1'b0, '0, 1'b0, 0); capture(); tick();
        drive(1'b0, 4'd0, '0, 1'b1, 4'd0, 4'd12, 4'd3);
        want("oor_after", '0, 1'b0, 32'hDEADBEEF, 1'b0, 0); capture(); tick();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0, 4'd10);
        want("zero_reserve", '0, 1'b0, '0, 1'b0, 0); capture(); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_bypass();
        snap_t e, o;
        drive(1'b0, 4'd0, '0, 1'b1, 4'd4, 4'd4, 4'd13); tick();
        drive(1'b1, 4'd4, 32'h99, 1'b0, 4'd0, 4'd4, 4'd13);
        want("byp_same", BYP ? 32'h99 : 32'h0, !BYP, '0, 1'b0, 1); capture(); tick();
        drive(1'b1, 4'd13, 32'hAB, 1'b0, 4'd0, 4'd4, 4'd13);
        want("byp_oor", 32'h99, 1'b0, '0, 1'b0, 0); capture(); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        logic [DW-1:0] prev;
        for (int i = 1; i < NR; i++) begin
            prev = (i == 1) ? 32'h0 : 32'(i - 1) * 32'h01010101;
            drive(1'b1, SW'(i), 32'(i) * 32'h01010101, 1'b0, 4'd0, SW'(i - 1), SW'(i - 1));
            want("b2b", prev, 1'b0, prev, 1'b0, 0); capture(); tick();
        end
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd9, 4'd5);
        want("b2b_final", 32'h09090909, 1'b0, 32'h05050505, 1'b0, 0); capture(); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (o.data[p] !== e.data[p] || o.busy[p] !== e.busy[p]) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, p, o.data[p], o.busy[p], e.data[p], e.busy[p]);
                end
            end
            n_checks++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d, want %0d", e.name, o.cnt, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_out_of_range();
        test_bypass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
